// File: rtl/packet_framer.sv
// packet_framer: wraps TLP/DLLP payload bytes in STP/SDP ... END/EDB framing symbols.
module packet_framer #(
  parameter int DLLP_LEN    = 6,
  parameter int MAX_TLP_LEN = 4096
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       tlp_valid,
  input  logic [7:0] tlp_data,
  input  logic       tlp_last,
  input  logic       tlp_abort,
  output logic       tlp_ready,
  input  logic       dllp_valid,
  input  logic [7:0] dllp_data,
  output logic       dllp_ready,
  input  logic       out_ready,
  output logic [7:0] data_out,
  output logic       dk_out,
  output logic       valid_out,
  output logic       overrun,
  output logic       busy
);
  localparam int CW = $clog2(MAX_TLP_LEN + 1);
  localparam logic [7:0] STP = 8'hFB;
  localparam logic [7:0] SDP = 8'h5C;
  localparam logic [7:0] END = 8'hFD;
  localparam logic [7:0] EDB = 8'hFE;
  typedef enum logic [2:0] {IDLE, DLLP_DATA, DLLP_END, TLP_DATA, TLP_END, DRAIN} state_t;
  state_t        state_q;
  logic [CW-1:0] cnt_q;
  logic          last_dllp_q, abort_q, drain_q;
  logic [7:0]    data_q;
  logic          dk_q, valid_q, overrun_q;
  logic          adv;
  assign adv        = !valid_q || out_ready;
  assign tlp_ready  = (state_q == TLP_DATA && adv) || state_q == DRAIN;
  assign dllp_ready = state_q == DLLP_DATA && adv;
  assign data_out   = data_q;
  assign dk_out     = dk_q;
  assign valid_out  = valid_q;
  assign overrun    = overrun_q;
  assign busy       = state_q != IDLE;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      last_dllp_q <= 1'b0;
      abort_q     <= 1'b0;
      drain_q     <= 1'b0;
      data_q      <= 8'h00;
      dk_q        <= 1'b0;
      valid_q     <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      overrun_q <= 1'b0;
      case (state_q)
        IDLE: if (adv) begin
          // DLLP wins unless a TLP is also waiting and the previous packet was a DLLP
          if (dllp_valid && (!tlp_valid || !last_dllp_q)) begin
            {valid_q, dk_q, data_q} <= {2'b11, SDP};
            cnt_q       <= '0;
            last_dllp_q <= 1'b1;
            state_q     <= DLLP_DATA;
          end else if (tlp_valid) begin
            {valid_q, dk_q, data_q} <= {2'b11, STP};
            cnt_q       <= '0;
            last_dllp_q <= 1'b0;
            state_q     <= TLP_DATA;
          end else valid_q <= 1'b0;
        end
        DLLP_DATA: if (dllp_valid && adv) begin
          {valid_q, dk_q, data_q} <= {2'b10, dllp_data};
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == CW'(DLLP_LEN - 1)) state_q <= DLLP_END;
        end else if (adv) valid_q <= 1'b0;
        DLLP_END: if (adv) begin
          {valid_q, dk_q, data_q} <= {2'b11, END};
          state_q <= IDLE;
        end
        TLP_DATA: if (tlp_valid && adv) begin
          {valid_q, dk_q, data_q} <= {2'b10, tlp_data};
          cnt_q <= cnt_q + 1'b1;
          if (tlp_last) begin
            abort_q <= tlp_abort;
            state_q <= TLP_END;
          end else if (cnt_q + CW'(1) == CW'(MAX_TLP_LEN)) begin
            abort_q   <= 1'b1;
            drain_q   <= 1'b1;
            overrun_q <= 1'b1;
            state_q   <= TLP_END;
          end
        end else if (adv) valid_q <= 1'b0;
        TLP_END: if (adv) begin
          {valid_q, dk_q, data_q} <= {2'b11, abort_q ? EDB : END};
          state_q <= drain_q ? DRAIN : IDLE;
        end
        DRAIN: begin
          if (adv) valid_q <= 1'b0;
          if (tlp_valid && tlp_last) begin
            drain_q <= 1'b0;
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_packet_framer.sv
// tb_packet_framer: directed scoreboard bench for packet_framer (MAX_TLP_LEN = 4).
module tb_packet_framer;
  logic       clk, rst_n;
  logic       tlp_valid, tlp_last, tlp_abort, tlp_ready;
  logic [7:0] tlp_data, dllp_data, data_out;
  logic       dllp_valid, dllp_ready, out_ready;
  logic       dk_out, valid_out, overrun, busy;
  int         tests, failed, ov_cnt, dllp_x;
  logic [8:0] exp_q [$];
  logic [8:0] e;
  packet_framer #(.DLLP_LEN(6), .MAX_TLP_LEN(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .tlp_valid(tlp_valid), .tlp_data(tlp_data), .tlp_last(tlp_last),
    .tlp_abort(tlp_abort), .tlp_ready(tlp_ready),
    .dllp_valid(dllp_valid), .dllp_data(dllp_data), .dllp_ready(dllp_ready),
    .out_ready(out_ready), .data_out(data_out), .dk_out(dk_out),
    .valid_out(valid_out), .overrun(overrun), .busy(busy)
  );
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(negedge clk)
    if (rst_n) begin
      if (overrun) ov_cnt++;
      if (dllp_valid && dllp_ready) dllp_x++;
      if (valid_out && out_ready) begin
        tests++;
        if (exp_q.size() == 0) begin
          failed++;
          $error("FAIL sb_extra got %h/%0b exp none", data_out, dk_out);
        end else begin
          e = exp_q.pop_front();
          assert ({dk_out, data_out} === e) else begin
            failed++;
            $error("FAIL sb_symbol got %0b/%h exp %0b/%h", dk_out, data_out, e[8], e[7:0]);
          end
        end
      end
    end
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      failed++;
      $error("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask
  task automatic push(input logic k, input logic [7:0] d);
    exp_q.push_back({k, d});
  endtask
  task automatic exp_tlp(input logic [7:0] base, input logic [7:0] step, input int n, input logic [7:0] ec);
    push(1'b1, 8'hFB);
    for (int i = 0; i < n; i++) push(1'b0, 8'(base + i * step));
    push(1'b1, ec);
  endtask
  task automatic exp_dllp(input logic [7:0] base);
    push(1'b1, 8'h5C);
    for (int i = 0; i < 6; i++) push(1'b0, 8'(base + i));
    push(1'b1, 8'hFD);
  endtask
  task automatic tlp_byte(input logic [7:0] d, input logic l, input logic a);
    int n;
    tlp_valid = 1'b1; tlp_data = d; tlp_last = l; tlp_abort = a;
    for (n = 0; n < 200; n++) begin
      @(negedge clk);
      if (tlp_ready) break;
    end
    chk("tlp_xfer_timeout", 32'(n < 200), 32'd1);
    @(posedge clk); #1;
    tlp_valid = 1'b0; tlp_last = 1'b0; tlp_abort = 1'b0;
  endtask
  task automatic dllp_byte(input logic [7:0] d);
    int n;
    dllp_valid = 1'b1; dllp_data = d;
    for (n = 0; n < 200; n++) begin
      @(negedge clk);
      if (dllp_ready) break;
    end
    chk("dllp_xfer_timeout", 32'(n < 200), 32'd1);
    @(posedge clk); #1;
    dllp_valid = 1'b0;
  endtask
  task automatic send_tlp(input logic [7:0] base, input logic [7:0] step, input int n, input logic a);
    for (int i = 0; i < n; i++) tlp_byte(8'(base + i * step), i == n - 1, a);
  endtask
  task automatic send_dllp(input logic [7:0] base);
    for (int i = 0; i < 6; i++) dllp_byte(8'(base + i));
  endtask
  task automatic drain(input string tag);
    int n;
    for (n = 0; n < 500 && exp_q.size() != 0; n++) @(negedge clk);
    chk(tag, exp_q.size(), 0);
    @(posedge clk); #1;
  endtask
  initial begin
    tests = 0; failed = 0; ov_cnt = 0; dllp_x = 0;
    rst_n = 1'b0; out_ready = 1'b1;
    tlp_valid = 1'b0; tlp_data = 8'h00; tlp_last = 1'b0; tlp_abort = 1'b0;
    dllp_valid = 1'b0; dllp_data = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_valid", valid_out, 0);
    chk("rst_data", data_out, 0);
    chk("rst_dk", dk_out, 0);
    chk("rst_overrun", overrun, 0);
    chk("rst_busy", busy, 0);
    chk("rst_ready", {tlp_ready, dllp_ready}, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    // both sources continuously requesting: DLLP, TLP, DLLP, TLP
    exp_dllp(8'hA0); exp_tlp(8'hC1, 8'h01, 2, 8'hFD);
    exp_dllp(8'hB0); exp_tlp(8'hD1, 8'h01, 3, 8'hFD);
    fork
      begin send_dllp(8'hA0); send_dllp(8'hB0); end
      begin send_tlp(8'hC1, 8'h01, 2, 1'b0); send_tlp(8'hD1, 8'h01, 3, 1'b0); end
    join
    drain("alt_drain");
    dllp_x = 0;
    exp_dllp(8'h01);
    send_dllp(8'h01);
    drain("dllp_drain");
    chk("dllp_xfers", dllp_x, 6);
    chk("dllp_idle", busy, 0);
    exp_tlp(8'hAA, 8'h11, 3, 8'hFD);
    send_tlp(8'hAA, 8'h11, 3, 1'b0);
    drain("tlp_end_drain");
    exp_tlp(8'hAA, 8'h11, 3, 8'hFE);
    send_tlp(8'hAA, 8'h11, 3, 1'b1);
    drain("tlp_edb_drain");
    // stall mid-TLP; 4-byte TLP ends exactly at the max length
    exp_tlp(8'h31, 8'h01, 4, 8'hFD);
    fork
      send_tlp(8'h31, 8'h01, 4, 1'b0);
      begin
        repeat (3) @(posedge clk);
        #1;
        out_ready = 1'b0;
        repeat (3) begin
          @(posedge clk); #1;
          chk("stall_data", {valid_out, dk_out, data_out}, {2'b10, 8'h32});
          chk("stall_ready", tlp_ready, 0);
        end
        out_ready = 1'b1;
      end
    join
    drain("stall_drain");
    chk("exact_max_no_overrun", ov_cnt, 0);
    exp_tlp(8'h40, 8'h01, 4, 8'hFE);
    send_tlp(8'h40, 8'h01, 7, 1'b0);
    drain("overrun_drain");
    chk("overrun_pulses", ov_cnt, 1);
    chk("overrun_idle", busy, 0);
    exp_tlp(8'h5A, 8'h01, 1, 8'hFD);
    send_tlp(8'h5A, 8'h01, 1, 1'b0);
    drain("post_drain_tlp");
    // reset after STP + 2 bytes abandons the packet
    push(1'b1, 8'hFB); push(1'b0, 8'h11); push(1'b0, 8'h22);
    tlp_byte(8'h11, 1'b0, 1'b0);
    tlp_byte(8'h22, 1'b0, 1'b0);
    @(negedge clk); #1;
    rst_n = 1'b0;
    #1;
    chk("midrst_valid", valid_out, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_left", exp_q.size(), 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    exp_tlp(8'h77, 8'h01, 2, 8'hFD);
    send_tlp(8'h77, 8'h01, 2, 1'b0);
    drain("after_rst_drain");
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end
endmodule

// File: doc/packet_framer.md
Name: packet_framer

Overview:
- Transmit-side framer for the 8-bit PCIe-style symbol stream.
- Accepts TLP and DLLP payload bytes from two upstream sources over valid/ready handshakes.
- Emits a single byte stream with a K/D flag, wrapping each packet in framing symbols: STP…END, SDP…END, or STP…EDB for a nullified TLP.
- Sits between the transaction/data-link layer sources and the lane driver. Its output is exactly the stream the receive-side packet identifier decodes.

Parameters:
- DLLP_LEN, 6: fixed DLLP payload length in bytes, excluding framing symbols.
- MAX_TLP_LEN, 4096: maximum TLP payload bytes; exceeding it forces nullification.

Ports:
- clk  input  1  single clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- tlp_valid  input  1  TLP byte available
- tlp_data  input  8  TLP payload byte
- tlp_last  input  1  qualifies last TLP byte
- tlp_abort  input  1  sampled with tlp_last; 1 = nullify (EDB)
- tlp_ready  output  1  framer accepts TLP byte this cycle
- dllp_valid  input  1  DLLP byte available
- dllp_data  input  8  DLLP payload byte
- dllp_ready  output  1  framer accepts DLLP byte this cycle
- out_ready  input  1  downstream accepts output byte
- data_out  output  8  symbol byte
- dk_out  output  1  1 = K symbol, 0 = data
- valid_out  output  1  data_out/dk_out valid
- overrun  output  1  one-cycle pulse on TLP length overrun
- busy  output  1  state != IDLE

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-low.
- Symbol codes:
  - STP = 0xFB, SDP = 0x5C, END = 0xFD, EDB = 0xFE.
  - Payload bytes equal to these codes are sent with dk_out = 0; no escaping.
- Reset values: valid_out = 0, data_out = 0x00, dk_out = 0, overrun = 0, state = IDLE, counters = 0, last_was_dllp = 0.
- Reset mid-packet: the packet is abandoned; no END/EDB is sent.
- Output register and handshake:
  - Outputs are registered.
  - adv = !valid_out || out_ready. The register loads only when adv = 1; otherwise it holds.
  - Upstream transfer occurs when ready && valid.
  - tlp_ready / dllp_ready are combinational from state and adv.
- States: IDLE, DLLP_DATA, DLLP_END, TLP_DATA, TLP_END, DRAIN.
- IDLE, when adv:
  - If dllp_valid && (!tlp_valid || !last_was_dllp): load SDP (dk = 1), clear cnt, go to DLLP_DATA, set last_was_dllp = 1.
  - Else if tlp_valid: load STP (dk = 1), clear cnt, go to TLP_DATA, set last_was_dllp = 0.
  - Else: valid_out <= 0.
  - Both ready signals are 0 in IDLE; the start symbol consumes no payload byte.
  - Latency: a request seen in cycle N gives STP/SDP on valid_out in cycle N+1.
- DLLP_DATA:
  - dllp_ready = adv.
  - On transfer: load byte (dk = 0), cnt++. When cnt == DLLP_LEN-1 is transferred, go to DLLP_END.
  - If adv with no transfer: valid_out <= 0 (gap allowed; the receiver holds packet context through invalid cycles).
- DLLP_END: when adv, load END (dk = 1), go to IDLE.
- TLP_DATA:
  - tlp_ready = adv.
  - On transfer: load byte, cnt++.
  - If tlp_last: capture abort_r = tlp_abort, go to TLP_END.
  - Else if cnt+1 == MAX_TLP_LEN: set abort_r = 1, drain_r = 1, overrun pulse, go to TLP_END.
  - Gaps are handled as in DLLP_DATA.
  - A last byte arriving exactly at MAX_TLP_LEN is legal: no overrun.
- TLP_END: when adv, load EDB if abort_r else END (dk = 1); go to DRAIN if drain_r else IDLE.
- DRAIN:
  - tlp_ready = 1. Incoming TLP bytes are discarded; valid_out <= 0 when adv.
  - On a transfer with tlp_last: clear drain_r, go to IDLE.
  - DLLPs wait until DRAIN exits.
- tlp_abort is ignored when tlp_last = 0.
- Counter width is $clog2(MAX_TLP_LEN+1) bits; no wrap occurs because overrun triggers first.
- Back-to-back packets: END in cycle N, next STP/SDP no earlier than N+1.

Test Plan:
- DLLP 6 bytes 0x01..0x06, out_ready = 1 → valid stream 5C(K), 01..06(D), FD(K); 8 output cycles; dllp_ready high for exactly 6 transfers.
- TLP 3 bytes AA, BB, CC with tlp_last on CC, abort = 0 → FB(K), AA, BB, CC, FD(K). Repeat with abort = 1 → last symbol FE(K).
- tlp_valid and dllp_valid both asserted continuously → order SDP-pkt, STP-pkt, SDP-pkt (alternation); no starvation over 4 packets.
- out_ready low for 3 cycles mid-TLP → data_out held stable, tlp_ready = 0 during stall, no byte lost or duplicated.
- MAX_TLP_LEN = 4, send 7 bytes with last on byte 7 → FB, 4 data bytes, FE(K), overrun pulse once, bytes 5–7 consumed and not emitted, then IDLE.
- Assert rst_n = 0 after STP + 2 bytes → valid_out = 0 immediately, busy = 0; the next packet starts cleanly with STP.
